// File: rtl/vga_reg_pkg.sv
// vga_reg_pkg
//   Shared definitions for the VGA register bus master and its users:
//   command op encodings, VGA register addresses, control/status bit
//   positions and the bus-cycle FSM state encoding.
package vga_reg_pkg;

    // Command op encodings carried on cmd_op
    typedef enum logic [1:0] {
        OP_WR   = 2'b00,
        OP_RD   = 2'b01,
        OP_POLL = 2'b10,
        OP_NOP  = 2'b11
    } vga_op_e;

    // VGA responder register map
    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_BGCOL = 2'd1;

    // Control/status register bit positions
    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_MODE_MSB = 1;
    localparam int CTRL_PLANE    = 2;
    localparam int CTRL_EN_IRQ   = 3;
    localparam int CTRL_VSYNC    = 4;   // active low: 0 means in vsync
    localparam int CTRL_HSYNC    = 5;

    // Bus-cycle FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4
    } vga_state_e;

endpackage

// File: rtl/vga_reg_master.sv
// vga_reg_master
//   Bus-cycle initiator for the VGA register responder on the Mini8086 I/O
//   bus. Turns single-beat write / read / poll-vsync / nop commands into
//   timed _vga_io/_wr/addr/data cycles and reports each completion with a
//   one-cycle rsp_valid pulse.
//
// Handshake: a command is accepted on any rising edge where
//   cmd_valid && cmd_ready; cmd_ready is high exactly in IDLE. op/addr/wdata
//   are registered at accept. The response has no backpressure: rsp_valid is
//   high for one cycle and rsp_rdata/rsp_timeout hold until the next response.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake
//   cmd_op/addr/wdata command payload (op 00 wr, 01 rd, 10 poll, 11 nop)
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         read/poll data
//   rsp_timeout       poll iteration limit reached
//   addr              bus register address
//   _vga_io, _wr      active-low register select / write strobes
//   data_out, data_oe write data and its drive enable
//   data_in           bus read data
//   dbg_state_o       current FSM state, for observation only
module vga_reg_master
    import vga_reg_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int POLL_LIMIT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic [1:0] addr,
    output logic       _vga_io,
    output logic       _wr,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in,
    output vga_state_e dbg_state_o
);

    // Last phase-counter value of each bus phase
    localparam logic [3:0]  SETUP_LAST  = 4'(SETUP_CYC - 1);
    localparam logic [3:0]  STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0]  HOLD_LAST   = 4'(HOLD_CYC - 1);
    localparam logic [15:0] POLL_LAST   = 16'(POLL_LIMIT);

    vga_state_e  state_q;
    vga_op_e     op_q;
    logic [3:0]  phase_q;
    logic [15:0] iter_q;
    logic [15:0] iter_d;
    logic [7:0]  rd_q;        // value captured at the end of the last strobe
    logic [1:0]  addr_q;
    logic [7:0]  data_out_q;
    logic        data_oe_q;
    logic        vga_io_n_q;
    logic        wr_n_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic        rsp_timeout_q;

    assign cmd_ready = (state_q == ST_IDLE);
    assign iter_d    = iter_q + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_NOP;
            phase_q       <= 4'd0;
            iter_q        <= 16'd0;
            rd_q          <= 8'h00;
            addr_q        <= 2'd0;
            data_out_q    <= 8'h00;
            data_oe_q     <= 1'b0;
            vga_io_n_q    <= 1'b1;
            wr_n_q        <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= vga_op_e'(cmd_op);
                        phase_q <= 4'd0;
                        iter_q  <= 16'd0;
                        if (cmd_op == OP_NOP) begin
                            state_q       <= ST_RESP;
                            rsp_valid_q   <= 1'b1;
                            rsp_rdata_q   <= 8'h00;
                            rsp_timeout_q <= 1'b0;
                        end else begin
                            state_q    <= ST_SETUP;
                            // Polling always targets the control/status register
                            addr_q     <= (cmd_op == OP_POLL) ? REG_CTRL : cmd_addr;
                            data_oe_q  <= (cmd_op == OP_WR);
                            data_out_q <= (cmd_op == OP_WR) ? cmd_wdata : 8'h00;
                        end
                    end
                end

                ST_SETUP: begin
                    if (phase_q == SETUP_LAST) begin
                        state_q    <= ST_STROBE;
                        phase_q    <= 4'd0;
                        vga_io_n_q <= 1'b0;
                        wr_n_q     <= (op_q == OP_WR) ? 1'b0 : 1'b1;
                    end else begin
                        phase_q <= phase_q + 4'd1;
                    end
                end

                ST_STROBE: begin
                    if (phase_q == STROBE_LAST) begin
                        state_q    <= ST_HOLD;
                        phase_q    <= 4'd0;
                        rd_q       <= data_in;
                        vga_io_n_q <= 1'b1;
                        wr_n_q     <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 4'd1;
                    end
                end

                ST_HOLD: begin
                    if (phase_q == HOLD_LAST) begin
                        phase_q <= 4'd0;
                        if (op_q == OP_POLL && rd_q[CTRL_VSYNC]) begin
                            // Not yet in vsync: count the iteration and retry or give up
                            iter_q <= iter_d;
                            if (iter_d == POLL_LAST) begin
                                state_q       <= ST_RESP;
                                rsp_valid_q   <= 1'b1;
                                rsp_rdata_q   <= rd_q;
                                rsp_timeout_q <= 1'b1;
                                data_oe_q     <= 1'b0;
                            end else begin
                                state_q <= ST_SETUP;
                            end
                        end else begin
                            state_q       <= ST_RESP;
                            rsp_valid_q   <= 1'b1;
                            rsp_rdata_q   <= (op_q == OP_WR) ? 8'h00 : rd_q;
                            rsp_timeout_q <= 1'b0;
                            data_oe_q     <= 1'b0;
                        end
                    end else begin
                        phase_q <= phase_q + 4'd1;
                    end
                end

                ST_RESP: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;
    assign addr        = addr_q;
    assign _vga_io     = vga_io_n_q;
    assign _wr         = wr_n_q;
    assign data_out    = data_out_q;
    assign data_oe     = data_oe_q;
    assign dbg_state_o = state_q;

endmodule
